fifo_bus_drain: RTL and testbench

- Read-side engine for the 16-deep, 32-bit bus FIFO. It pops words through the FIFO's show-ahead read port (data visible while not empty; `r_en` pops on the clock edge).
- Issues the popped words as address-incrementing write beats on the bus master port, using a valid/ready handshake.
- Sends full bursts when the FIFO reports half-full, and drains leftovers as single beats after an idle timeout.
- This block is the only reader of its FIFO.

---
 rtl/bus_pkg.sv | 19 +
 rtl/drain_timeout_timer.sv | 27 ++
 rtl/fifo_bus_drain.sv | 140 ++++++++++++++
 tb/tb_fifo_bus_drain.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared types and FIFO geometry for the bus FIFO and its drain engine.
// Holds the drain state encoding and the legality check used on the burst length.
package bus_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BURST = 2'd1,
      FLUSH = 2'd2
   } state_t;

   localparam int FIFO_DEPTH = 16;
   localparam int FIFO_HALF  = 8;

   // A burst may never ask for more words than half_full guarantees are present.
   function automatic bit burst_len_ok(input int len);
      return (len >= 1) && (len <= FIFO_HALF);
   endfunction

endpackage

// File: rtl/drain_timeout_timer.sv
// Idle timer for the drain engine: counts while en, tc pulses in the cycle the count is TIMEOUT-1.
// Latency: tc is combinational on the count; clr and tc both return the count to zero; no backpressure.
module drain_timeout_timer #(
   parameter int TIMEOUT = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   logic [TW-1:0] count;

   assign tc = en && (count == TW'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (rst || clr || tc) begin
         count <= '0;
      end else if (en) begin
         count <= count + TW'(1);
      end
   end

endmodule

// File: rtl/fifo_bus_drain.sv
// Drains the show-ahead bus FIFO into address-incrementing write beats: bursts on half_full, single-beat flush after an idle timeout.
// Latency: start in IDLE at N, pop at N+1, bus_valid at N+2; a stalled beat holds every bus output and blocks further pops.
module fifo_bus_drain
   import bus_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 32,
   parameter int BURST_LEN = 8,
   parameter int ADDR_STEP = 4,
   parameter int TIMEOUT   = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fifo_empty,
   input  logic              fifo_half_full,
   input  logic [DATA_W-1:0] fifo_data,
   output logic              fifo_r_en,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              addr_load,
   output logic              bus_valid,
   input  logic              bus_ready,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_data,
   output logic              bus_last,
   output logic              busy,
   output logic [15:0]       words_sent
);

   if (!burst_len_ok(BURST_LEN)) begin : g_bad_burst_len
      $error("fifo_bus_drain: BURST_LEN must be in 1..%0d", FIFO_HALF);
   end
   if (TIMEOUT < 2) begin : g_bad_timeout
      $error("fifo_bus_drain: TIMEOUT must be at least 2");
   end

   localparam int FW = $clog2(BURST_LEN + 1);

   state_t              state, state_nxt;
   logic                hv, hl;
   logic [DATA_W-1:0]   hd;
   logic [ADDR_W-1:0]   addr;
   logic [FW-1:0]       fetched;
   logic [15:0]         sent_cnt;
   logic                accept, fetch_ok, pop;
   logic                timer_en, timer_clr, timer_tc;

   assign bus_valid  = hv;
   assign bus_data   = hd;
   assign bus_last   = hv && hl;
   assign bus_addr   = addr;
   assign words_sent = sent_cnt;
   assign busy       = (state != IDLE) || hv;

   assign accept    = hv && bus_ready;
   assign timer_en  = (state == IDLE) && !fifo_empty && !fifo_half_full;
   assign timer_clr = (state != IDLE) || fifo_empty;

   drain_timeout_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk (clk),
      .rst (rst),
      .clr (timer_clr),
      .en  (timer_en),
      .tc  (timer_tc)
   );

   always_comb begin
      state_nxt = state;
      fetch_ok  = 1'b0;
      case (state)
         IDLE: begin
            if (fifo_half_full) begin
               state_nxt = BURST;
            end else if (timer_tc) begin
               state_nxt = FLUSH;
            end
         end
         BURST: begin
            fetch_ok = (fetched < FW'(BURST_LEN));
            if (accept && hl) begin
               state_nxt = IDLE;
            end
         end
         FLUSH: begin
            // No flush pop once half_full is seen, so the burst starts with an empty holding register.
            fetch_ok = !fifo_half_full && (!hv || accept);
            if (fifo_half_full && (accept || !hv)) begin
               state_nxt = BURST;
            end else if (fifo_empty && (accept || !hv)) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Gated by rst so a reset cycle never pops a word the engine would then discard.
   assign pop       = !rst && !fifo_empty && fetch_ok && (!hv || accept);
   assign fifo_r_en = pop;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         hv       <= 1'b0;
         hl       <= 1'b0;
         hd       <= '0;
         addr     <= '0;
         fetched  <= '0;
         sent_cnt <= '0;
      end else begin
         state <= state_nxt;

         if ((state == IDLE) && addr_load) begin
            addr <= base_addr;
         end else if (accept) begin
            addr <= addr + ADDR_W'(ADDR_STEP);
         end

         if (accept) begin
            sent_cnt <= sent_cnt + 16'd1;
         end

         if (pop) begin
            hv <= 1'b1;
            hd <= fifo_data;
            hl <= (state == FLUSH) || (fetched == FW'(BURST_LEN - 1));
         end else if (accept) begin
            hv <= 1'b0;
         end

         if (state_nxt != BURST) begin
            fetched <= '0;
         end else if (pop) begin
            fetched <= fetched + FW'(1);
         end
      end
   end

endmodule

// File: tb/tb_fifo_bus_drain.sv
// Bench for fifo_bus_drain: a queue-backed show-ahead FIFO feeds the DUT and accepted beats are
// compared with beat lists built from the pushed words, the address arithmetic and the burst/flush last rule.
module tb_fifo_bus_drain;

   localparam int TIMEOUT = 64;

   logic        clk = 1'b0;
   logic        rst;
   logic        fifo_empty;
   logic        fifo_half_full;
   logic [31:0] fifo_data;
   logic        fifo_r_en;
   logic [31:0] base_addr;
   logic        addr_load;
   logic        bus_valid;
   logic        bus_ready;
   logic [31:0] bus_addr;
   logic [31:0] bus_data;
   logic        bus_last;
   logic        busy;
   logic [15:0] words_sent;

   always #5 clk = ~clk;

   fifo_bus_drain #(
      .DATA_W    (32),
      .ADDR_W    (32),
      .BURST_LEN (8),
      .ADDR_STEP (4),
      .TIMEOUT   (TIMEOUT)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .fifo_empty     (fifo_empty),
      .fifo_half_full (fifo_half_full),
      .fifo_data      (fifo_data),
      .fifo_r_en      (fifo_r_en),
      .base_addr      (base_addr),
      .addr_load      (addr_load),
      .bus_valid      (bus_valid),
      .bus_ready      (bus_ready),
      .bus_addr       (bus_addr),
      .bus_data       (bus_data),
      .bus_last       (bus_last),
      .busy           (busy),
      .words_sent     (words_sent)
   );

   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
      logic        l;
      int          c;
   } beat_t;

   logic [31:0] fq[$];
   logic [31:0] pend[$];
   beat_t       got[$];
   int          rdy_mode;
   int          cyc;
   int          errors, checks;
   int          n_underflow, n_unstable, n_stall_pop;
   int          first_hf, first_ne, first_rd, first_vld;
   logic        pv, pr, pl, s_pop;
   logic [31:0] pa, pd;
   logic [31:0] m_addr;
   logic [15:0] m_sent;

   task automatic drive_fifo();
      fifo_empty     = (fq.size() == 0);
      fifo_half_full = (fq.size() >= 8);
      fifo_data      = (fq.size() == 0) ? 32'd0 : fq[0];
   endtask

   // One clock: observe at the falling edge, then update the FIFO model and inputs just after the rising edge.
   task automatic cycle();
      beat_t b;
      @(negedge clk);
      if (fifo_r_en === 1'b1 && fifo_empty) n_underflow++;
      if (pv === 1'b1 && pr === 1'b0 &&
          !(bus_valid === 1'b1 && bus_addr === pa && bus_data === pd && bus_last === pl)) n_unstable++;
      if (bus_valid === 1'b1 && bus_ready === 1'b0 && fifo_r_en === 1'b1) n_stall_pop++;
      if (bus_valid === 1'b1 && bus_ready === 1'b1) begin
         b.a = bus_addr; b.d = bus_data; b.l = bus_last; b.c = cyc;
         got.push_back(b);
      end
      if (first_hf < 0 && fifo_half_full) first_hf = cyc;
      if (first_ne < 0 && !fifo_empty) first_ne = cyc;
      if (first_rd < 0 && fifo_r_en === 1'b1) first_rd = cyc;
      if (first_vld < 0 && bus_valid === 1'b1) first_vld = cyc;
      pv = bus_valid; pr = bus_ready; pa = bus_addr; pd = bus_data; pl = bus_last;
      s_pop = (fifo_r_en === 1'b1);
      @(posedge clk);
      #1;
      cyc++;
      if (s_pop && fq.size() > 0) void'(fq.pop_front());
      if (pend.size() > 0 && fq.size() < 16) fq.push_back(pend.pop_front());
      case (rdy_mode)
         0:       bus_ready = 1'b1;
         1:       bus_ready = !bus_ready;
         2:       bus_ready = 1'($urandom_range(0, 1));
         default: bus_ready = 1'b0;
      endcase
      drive_fifo();
   endtask

   task automatic clear_mon();
      got.delete();
      first_hf = -1; first_ne = -1; first_rd = -1; first_vld = -1;
      n_unstable = 0; n_stall_pop = 0;
   endtask

   task automatic run_until(input int n, input int budget);
      for (int k = 0; k < budget && got.size() < n; k++) cycle();
   endtask

   task automatic settle();
      for (int k = 0; k < 100 && busy !== 1'b0; k++) cycle();
   endtask

   task automatic load_base(input logic [31:0] a);
      base_addr = a;
      addr_load = 1'b1;
      cycle();
      addr_load = 1'b0;
      m_addr    = a;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cycle();
      cycle();
      checks++; if (bus_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", bus_valid); end
      checks++; if (fifo_r_en !== 1'b0) begin errors++; $display("FAIL reset_r_en got=%b want=0", fifo_r_en); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
      checks++; if (words_sent !== 16'd0) begin errors++; $display("FAIL reset_words got=%0d want=0", words_sent); end
      checks++; if (bus_addr !== 32'd0) begin errors++; $display("FAIL reset_addr got=%h want=0", bus_addr); end
      checks++; if (bus_last !== 1'b0) begin errors++; $display("FAIL reset_last got=%b want=0", bus_last); end
      rst = 1'b0;
      m_addr = 32'd0;
      m_sent = 16'd0;
   endtask

   task automatic test_burst();
      logic [31:0] w[8];
      clear_mon();
      load_base(32'h0000_1000);
      rdy_mode = 0;
      for (int i = 0; i < 8; i++) begin w[i] = 32'hA0 + 32'(i); pend.push_back(w[i]); end
      run_until(8, 200);
      settle();
      checks++; if (got.size() != 8) begin errors++; $display("FAIL burst_count got=%0d want=8", got.size()); end
      for (int i = 0; i < 8 && i < got.size(); i++) begin
         checks++;
         if (got[i].a !== m_addr + 32'(4 * i) || got[i].d !== w[i] || got[i].l !== (i == 7)) begin
            errors++;
            $display("FAIL burst_beat%0d got=%h/%h/%b want=%h/%h/%b", i, got[i].a, got[i].d, got[i].l,
                     m_addr + 32'(4 * i), w[i], (i == 7));
         end
      end
      checks++; if (first_vld - first_hf != 2) begin errors++; $display("FAIL burst_latency got=%0d want=2", first_vld - first_hf); end
      if (got.size() == 8) begin
         checks++; if (got[7].c - got[0].c != 7) begin errors++; $display("FAIL burst_b2b got=%0d want=7", got[7].c - got[0].c); end
      end
      m_addr += 32'd32;
      m_sent += 16'd8;
      checks++; if (words_sent !== m_sent) begin errors++; $display("FAIL burst_words got=%0d want=%0d", words_sent, m_sent); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL burst_idle got=%b want=0", busy); end
   endtask

   task automatic test_stall();
      logic [31:0] w[8];
      clear_mon();
      load_base(32'h0000_2000);
      rdy_mode  = 1;
      bus_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin w[i] = $urandom(); pend.push_back(w[i]); end
      run_until(8, 300);
      rdy_mode = 0;
      settle();
      checks++; if (got.size() != 8) begin errors++; $display("FAIL stall_count got=%0d want=8", got.size()); end
      for (int i = 0; i < 8 && i < got.size(); i++) begin
         checks++;
         if (got[i].a !== m_addr + 32'(4 * i) || got[i].d !== w[i] || got[i].l !== (i == 7)) begin
            errors++;
            $display("FAIL stall_beat%0d got=%h/%h/%b want=%h/%h/%b", i, got[i].a, got[i].d, got[i].l,
                     m_addr + 32'(4 * i), w[i], (i == 7));
         end
      end
      checks++; if (n_unstable != 0) begin errors++; $display("FAIL stall_stable got=%0d want=0", n_unstable); end
      checks++; if (n_stall_pop != 0) begin errors++; $display("FAIL stall_pop got=%0d want=0", n_stall_pop); end
      m_addr += 32'd32;
      m_sent += 16'd8;
      checks++; if (words_sent !== m_sent) begin errors++; $display("FAIL stall_words got=%0d want=%0d", words_sent, m_sent); end
   endtask

   task automatic test_flush();
      logic [31:0] w[3];
      clear_mon();
      rdy_mode = 0;
      for (int i = 0; i < 3; i++) begin w[i] = $urandom(); pend.push_back(w[i]); end
      run_until(3, 300);
      settle();
      checks++; if (first_rd - first_ne != TIMEOUT) begin errors++; $display("FAIL flush_delay got=%0d want=%0d", first_rd - first_ne, TIMEOUT); end
      checks++; if (got.size() != 3) begin errors++; $display("FAIL flush_count got=%0d want=3", got.size()); end
      for (int i = 0; i < 3 && i < got.size(); i++) begin
         checks++;
         if (got[i].a !== m_addr + 32'(4 * i) || got[i].d !== w[i] || got[i].l !== 1'b1) begin
            errors++;
            $display("FAIL flush_beat%0d got=%h/%h/%b want=%h/%h/1", i, got[i].a, got[i].d, got[i].l, m_addr + 32'(4 * i), w[i]);
         end
      end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_idle got=%b want=0", busy); end
      checks++; if (n_underflow != 0) begin errors++; $display("FAIL flush_underflow got=%0d want=0", n_underflow); end
      m_addr += 32'd12;
      m_sent += 16'd3;
   endtask

   task automatic test_reset_mid_burst();
      logic [31:0] exp_d[$];
      logic [31:0] w;
      int          n;
      clear_mon();
      rdy_mode = 0;
      for (int i = 0; i < 8; i++) pend.push_back($urandom());
      run_until(3, 200);
      rst = 1'b1;
      cycle();
      checks++; if (bus_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got=%b want=0", bus_valid); end
      checks++; if (fifo_r_en !== 1'b0) begin errors++; $display("FAIL rstmid_r_en got=%b want=0", fifo_r_en); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b want=0", busy); end
      rst = 1'b0;
      m_addr = 32'd0;
      m_sent = 16'd0;
      // Words still in the FIFO come out first, then the new ones: one burst of 8, remainder as flush singles.
      exp_d = fq;
      for (int i = 0; i < 8; i++) begin w = $urandom(); exp_d.push_back(w); pend.push_back(w); end
      n = exp_d.size();
      clear_mon();
      run_until(n, 500);
      settle();
      checks++; if (got.size() != n) begin errors++; $display("FAIL rstmid_count got=%0d want=%0d", got.size(), n); end
      for (int i = 0; i < n && i < got.size(); i++) begin
         checks++;
         if (got[i].a !== 32'(4 * i) || got[i].d !== exp_d[i] || got[i].l !== (i >= 7)) begin
            errors++;
            $display("FAIL rstmid_beat%0d got=%h/%h/%b want=%h/%h/%b", i, got[i].a, got[i].d, got[i].l,
                     32'(4 * i), exp_d[i], (i >= 7));
         end
      end
      m_addr = 32'(4 * n);
      m_sent = 16'(n);
      checks++; if (words_sent !== m_sent) begin errors++; $display("FAIL rstmid_words got=%0d want=%0d", words_sent, m_sent); end
   endtask

   task automatic test_wrap();
      logic [31:0] w[8];
      logic [31:0] ea;
      clear_mon();
      load_base(32'hFFFF_FFF8);
      rdy_mode = 2;
      for (int i = 0; i < 8; i++) begin w[i] = $urandom(); pend.push_back(w[i]); end
      run_until(8, 400);
      rdy_mode = 0;
      settle();
      checks++; if (got.size() != 8) begin errors++; $display("FAIL wrap_count got=%0d want=8", got.size()); end
      for (int i = 0; i < 8 && i < got.size(); i++) begin
         ea = m_addr + 32'(4 * i);
         checks++;
         if (got[i].a !== ea || got[i].d !== w[i] || got[i].l !== (i == 7)) begin
            errors++;
            $display("FAIL wrap_beat%0d got=%h/%h/%b want=%h/%h/%b", i, got[i].a, got[i].d, got[i].l, ea, w[i], (i == 7));
         end
      end
      checks++; if (n_unstable != 0) begin errors++; $display("FAIL wrap_stable got=%0d want=0", n_unstable); end
      m_addr += 32'd32;
      m_sent += 16'd8;
   endtask

   task automatic test_flush_to_burst();
      logic [31:0] w[10];
      clear_mon();
      load_base(32'h0000_5000);
      rdy_mode  = 3;
      bus_ready = 1'b0;
      for (int i = 0; i < 10; i++) w[i] = $urandom();
      pend.push_back(w[0]);
      pend.push_back(w[1]);
      for (int k = 0; k < 200 && bus_valid !== 1'b1; k++) cycle();
      checks++; if (bus_valid !== 1'b1) begin errors++; $display("FAIL f2b_flush_start got=%b want=1", bus_valid); end
      for (int i = 2; i < 10; i++) pend.push_back(w[i]);
      for (int k = 0; k < 50 && pend.size() > 0; k++) cycle();
      cycle();
      rdy_mode = 0;
      run_until(10, 400);
      settle();
      checks++; if (got.size() != 10) begin errors++; $display("FAIL f2b_count got=%0d want=10", got.size()); end
      for (int i = 0; i < 10 && i < got.size(); i++) begin
         checks++;
         if (got[i].a !== m_addr + 32'(4 * i) || got[i].d !== w[i] || got[i].l !== (i == 0 || i >= 8)) begin
            errors++;
            $display("FAIL f2b_beat%0d got=%h/%h/%b want=%h/%h/%b", i, got[i].a, got[i].d, got[i].l,
                     m_addr + 32'(4 * i), w[i], (i == 0 || i >= 8));
         end
      end
      checks++; if (n_unstable != 0) begin errors++; $display("FAIL f2b_stable got=%0d want=0", n_unstable); end
      checks++; if (n_stall_pop != 0) begin errors++; $display("FAIL f2b_stall_pop got=%0d want=0", n_stall_pop); end
      m_sent += 16'd10;
      checks++; if (words_sent !== m_sent) begin errors++; $display("FAIL f2b_words got=%0d want=%0d", words_sent, m_sent); end
      checks++; if (n_underflow != 0) begin errors++; $display("FAIL underflow_total got=%0d want=0", n_underflow); end
   endtask

   initial begin
      errors = 0; checks = 0; cyc = 0;
      n_underflow = 0;
      pv = 1'b0; pr = 1'b0; pl = 1'b0; pa = '0; pd = '0; s_pop = 1'b0;
      rdy_mode = 0; bus_ready = 1'b1;
      rst = 1'b1; addr_load = 1'b0; base_addr = '0;
      m_addr = '0; m_sent = '0;
      drive_fifo();
      clear_mon();
      test_reset();
      test_burst();
      test_stall();
      test_flush();
      test_reset_mid_burst();
      test_wrap();
      test_flush_to_burst();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "simulation time limit reached");
   end

endmodule
